// File: rtl/connect4_pkg.sv
// Shared Connect4 constants: board geometry, game FSM codes, result and piece
// codes, and the move sequencer's state encoding.
package connect4_pkg;

    localparam int ROWS  = 6;
    localparam int COLS  = 7;
    localparam int CELLS = ROWS * COLS;

    localparam logic [1:0] GAME_INIT = 2'b00;
    localparam logic [1:0] P1_TURN   = 2'b01;
    localparam logic [1:0] P2_TURN   = 2'b10;
    localparam logic [1:0] END_GAME  = 2'b11;

    localparam logic [1:0] NEXT_TURN  = 2'b00;
    localparam logic [1:0] PLAYER_WIN = 2'b01;
    localparam logic [1:0] TIE_GAME   = 2'b10;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    localparam logic [2:0] SEQ_CLEAR    = 3'd0;
    localparam logic [2:0] SEQ_IDLE     = 3'd1;
    localparam logic [2:0] SEQ_VALIDATE = 3'd2;
    localparam logic [2:0] SEQ_WRITE    = 3'd3;
    localparam logic [2:0] SEQ_CHECK    = 3'd4;
    localparam logic [2:0] SEQ_UPDATE   = 3'd5;

endpackage

// File: rtl/column_height_bank.sv
// Per-column fill heights for the board: one 3-bit counter per column, a full
// flag per column and a single increment port.
module column_height_bank
    import connect4_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                inc,
    input  logic [2:0]          inc_col,
    output logic [3*COLS-1:0]   heights,
    output logic [COLS-1:0]     full
);

    logic [3*COLS-1:0] heights_q;
    logic [3*COLS-1:0] heights_d;

    always_comb begin
        heights_d = heights_q;
        if (clear) begin
            heights_d = '0;
        end else if (inc) begin
            for (int i = 0; i < COLS; i++) begin
                // A full column never wraps back to zero.
                if (inc_col == i[2:0] && heights_q[i*3 +: 3] != 3'(ROWS)) begin
                    heights_d[i*3 +: 3] = heights_q[i*3 +: 3] + 3'd1;
                end
            end
        end
    end

    always_comb begin
        full = '0;
        for (int i = 0; i < COLS; i++) begin
            full[i] = (heights_q[i*3 +: 3] == 3'(ROWS));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) heights_q <= '0;
        else        heights_q <= heights_d;
    end

    assign heights = heights_q;

endmodule

// File: rtl/move_sequencer.sv
// Connect4 move sequencer: clears the board, validates and writes each drop,
// runs the win check and reports turn / result to the game FSM.
module move_sequencer
    import connect4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic [1:0] current_state,
    input  logic       drop_valid,
    input  logic [2:0] drop_col,
    output logic       board_we,
    output logic [2:0] board_row,
    output logic [2:0] board_col,
    output logic [1:0] board_piece,
    output logic       chk_start,
    input  logic       chk_done,
    input  logic       chk_win,
    output logic [1:0] in_game_status,
    output logic       player_turn,
    output logic       invalid_column,
    output logic       busy,
    output logic [2:0] state_dbg
);

    // Handshake: drop_valid is a one-cycle request, taken only in IDLE; chk_start
    // is a one-cycle pulse and the cell stays on board_* until chk_done is seen in CHECK.
    logic [2:0] state_q, state_d;
    logic [2:0] clr_row_q, clr_row_d;
    logic [2:0] clr_col_q, clr_col_d;
    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic [1:0] piece_q, piece_d;
    logic       we_q, we_d;
    logic       chk_start_q, chk_start_d;
    logic [1:0] status_q, status_d;
    logic       turn_q, turn_d;
    logic       invalid_q, invalid_d;
    logic       win_q, win_d;
    logic [5:0] count_q, count_d;
    logic       busy_q, busy_d;

    logic [3*COLS-1:0] heights;
    logic [COLS-1:0]   full;
    logic              inc;
    logic [2:0]        sel_h;
    logic              sel_full;
    logic              my_turn;

    column_height_bank u_heights (
        .clk     (clk),
        .rst_n   (reset),
        .clear   (new_game),
        .inc     (inc),
        .inc_col (col_q),
        .heights (heights),
        .full    (full)
    );

    // Out-of-range columns fall through with sel_full=1, so they are rejected too.
    always_comb begin
        sel_h    = '0;
        sel_full = 1'b1;
        for (int i = 0; i < COLS; i++) begin
            if (col_q == i[2:0]) begin
                sel_h    = heights[i*3 +: 3];
                sel_full = full[i];
            end
        end
    end

    assign my_turn = (current_state == P1_TURN && !turn_q) ||
                     (current_state == P2_TURN &&  turn_q);

    always_comb begin
        state_d     = state_q;
        clr_row_d   = clr_row_q;
        clr_col_d   = clr_col_q;
        row_d       = row_q;
        col_d       = col_q;
        piece_d     = piece_q;
        we_d        = 1'b0;
        chk_start_d = 1'b0;
        status_d    = status_q;
        turn_d      = turn_q;
        invalid_d   = invalid_q;
        win_d       = win_q;
        count_d     = count_q;
        inc         = 1'b0;

        case (state_q)
            SEQ_CLEAR: begin
                // clr_col reaching COLS marks the cycle after the last cleared cell.
                if (clr_col_q == 3'(COLS)) begin
                    state_d = SEQ_IDLE;
                end else begin
                    we_d    = 1'b1;
                    row_d   = clr_row_q;
                    col_d   = clr_col_q;
                    piece_d = EMPTY;
                    if (clr_row_q == 3'(ROWS - 1)) begin
                        clr_row_d = '0;
                        clr_col_d = clr_col_q + 3'd1;
                    end else begin
                        clr_row_d = clr_row_q + 3'd1;
                    end
                end
            end
            SEQ_IDLE: begin
                if (drop_valid && status_q == NEXT_TURN && my_turn) begin
                    col_d     = drop_col;
                    invalid_d = 1'b0;
                    state_d   = SEQ_VALIDATE;
                end
            end
            SEQ_VALIDATE: begin
                if (sel_full) begin
                    invalid_d = 1'b1;
                    state_d   = SEQ_IDLE;
                end else begin
                    row_d   = sel_h;
                    piece_d = turn_q ? P2 : P1;
                    we_d    = 1'b1;
                    state_d = SEQ_WRITE;
                end
            end
            SEQ_WRITE: begin
                inc         = 1'b1;
                count_d     = count_q + 6'd1;
                chk_start_d = 1'b1;
                state_d     = SEQ_CHECK;
            end
            SEQ_CHECK: begin
                if (chk_done) begin
                    win_d   = chk_win;
                    state_d = SEQ_UPDATE;
                end
            end
            SEQ_UPDATE: begin
                // A win on the last free cell still reports PLAYER_WIN.
                if (win_q)                       status_d = PLAYER_WIN;
                else if (count_q == 6'(CELLS))   status_d = TIE_GAME;
                else                             turn_d   = !turn_q;
                state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_CLEAR;
        endcase

        if (new_game) begin
            state_d     = SEQ_CLEAR;
            clr_row_d   = '0;
            clr_col_d   = '0;
            row_d       = '0;
            col_d       = '0;
            piece_d     = EMPTY;
            we_d        = 1'b0;
            chk_start_d = 1'b0;
            status_d    = NEXT_TURN;
            turn_d      = 1'b0;
            invalid_d   = 1'b0;
            win_d       = 1'b0;
            count_d     = '0;
        end
    end

    assign busy_d = (state_d != SEQ_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SEQ_CLEAR;
            clr_row_q   <= '0;
            clr_col_q   <= '0;
            row_q       <= '0;
            col_q       <= '0;
            piece_q     <= EMPTY;
            we_q        <= 1'b0;
            chk_start_q <= 1'b0;
            status_q    <= NEXT_TURN;
            turn_q      <= 1'b0;
            invalid_q   <= 1'b0;
            win_q       <= 1'b0;
            count_q     <= '0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_row_q   <= clr_row_d;
            clr_col_q   <= clr_col_d;
            row_q       <= row_d;
            col_q       <= col_d;
            piece_q     <= piece_d;
            we_q        <= we_d;
            chk_start_q <= chk_start_d;
            status_q    <= status_d;
            turn_q      <= turn_d;
            invalid_q   <= invalid_d;
            win_q       <= win_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
        end
    end

    assign board_we       = we_q;
    assign board_row      = row_q;
    assign board_col      = col_q;
    assign board_piece    = piece_q;
    assign chk_start      = chk_start_q;
    assign in_game_status = status_q;
    assign player_turn    = turn_q;
    assign invalid_column = invalid_q;
    assign busy           = busy_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: a game-level model (heights, piece count, status,
// turn) predicts board writes and results; directed cases plus random games.
module tb_move_sequencer;
  import connect4_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  logic [1:0] current_state = GAME_INIT;
  logic       drop_valid = 1'b0;
  logic [2:0] drop_col = 3'd0;
  logic       chk_done = 1'b0;
  logic       chk_win = 1'b0;
  logic       board_we;
  logic [2:0] board_row;
  logic [2:0] board_col;
  logic [1:0] board_piece;
  logic       chk_start;
  logic [1:0] in_game_status;
  logic       player_turn;
  logic       invalid_column;
  logic       busy;
  logic [2:0] state_dbg;

  int n_tests = 0;
  int n_fail = 0;

  // Expected board writes as {row, col, piece}.
  logic [7:0] exp_q[$];
  logic [7:0] last_w = 8'h00;

  int         mh[8];
  int         m_count = 0;
  logic [1:0] m_status = NEXT_TURN;
  logic       m_turn = 1'b0;
  logic       m_inv = 1'b0;
  logic       auto_resp = 1'b1;
  logic       next_win = 1'b0;

  move_sequencer dut (
    .clk            (clk),
    .reset          (rst_n),
    .new_game       (new_game),
    .current_state  (current_state),
    .drop_valid     (drop_valid),
    .drop_col       (drop_col),
    .board_we       (board_we),
    .board_row      (board_row),
    .board_col      (board_col),
    .board_piece    (board_piece),
    .chk_start      (chk_start),
    .chk_done       (chk_done),
    .chk_win        (chk_win),
    .in_game_status (in_game_status),
    .player_turn    (player_turn),
    .invalid_column (invalid_column),
    .busy           (busy),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mh[i] = 0;
    m_count  = 0;
    m_status = NEXT_TURN;
    m_turn   = 1'b0;
    m_inv    = 1'b0;
    exp_q.delete();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        exp_q.push_back({3'(r), 3'(c), EMPTY});
  endtask

  // Game rules applied to one request: acceptance, column validity, result.
  task automatic apply_model(input logic [2:0] col, input logic [1:0] cs, input logic win);
    bit accept;
    accept = (m_status == NEXT_TURN) &&
             ((cs == P1_TURN && !m_turn) || (cs == P2_TURN && m_turn));
    if (accept) begin
      if (int'(col) >= COLS || mh[col] == ROWS) begin
        m_inv = 1'b1;
      end else begin
        m_inv = 1'b0;
        exp_q.push_back({3'(mh[col]), col, m_turn ? P2 : P1});
        mh[col]++;
        m_count++;
        if (win)                  m_status = PLAYER_WIN;
        else if (m_count == CELLS) m_status = TIE_GAME;
        else                      m_turn = !m_turn;
      end
    end
  endtask

  // Win-checker stand-in: answers each chk_start after 1-3 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && chk_start && auto_resp) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 chk_done = 1'b1;
        chk_win = next_win;
        @(posedge clk);
        #1 chk_done = 1'b0;
        chk_win = 1'b0;
      end
    end
  end

  // Scoreboard: every write against the expected queue, check cell against the
  // last write, and result outputs against the model whenever the sequencer is idle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (board_we) begin
        check("we_busy", busy, 1);
        check("we_no_chk", chk_start, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", board_we, 0);
        end else begin
          last_w = exp_q.pop_front();
          check("write_cell", {board_row, board_col, board_piece}, last_w);
        end
      end
      if (chk_start) check("chk_cell", {board_row, board_col, board_piece}, last_w);
      if (!busy) begin
        check("status", in_game_status, m_status);
        check("turn", player_turn, m_turn);
        check("invalid", invalid_column, m_inv);
      end
    end
  end

  task automatic issue(input logic [2:0] col, input logic [1:0] cs, input logic win);
    @(posedge clk);
    #1 current_state = cs;
    drop_col   = col;
    drop_valid = 1'b1;
    next_win   = win;
    @(posedge clk);
    #1 drop_valid = 1'b0;
    apply_model(col, cs, win);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    check("idle_timeout", ok, 1);
  endtask

  task automatic drop(input logic [2:0] col, input logic [1:0] cs, input logic win);
    issue(col, cs, win);
    wait_idle();
  endtask

  task automatic play(input logic [2:0] col, input logic win);
    drop(col, m_turn ? P2_TURN : P1_TURN, win);
  endtask

  task automatic check_clear();
    int n = 0;
    bit seen_idle = 0;
    bit last_we = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen_idle = 1;
        break;
      end
      last_we = board_we;
      if (board_we) n++;
    end
    check("clear_writes", n, CELLS);
    check("clear_idle", seen_idle, 1);
    check("clear_last_we", last_we, 1);
    check("clear_queue_empty", exp_q.size(), 0);
  endtask

  task automatic restart();
    check("queue_empty_before_restart", exp_q.size(), 0);
    @(posedge clk);
    #1 new_game = 1'b1;
    @(posedge clk);
    #1 new_game = 1'b0;
    model_reset();
    check_clear();
  endtask

  initial begin
    int k;
    bit seen;
    logic [1:0] cs;

    // Reset values.
    #12;
    check("rst_we", board_we, 0);
    check("rst_chk", chk_start, 0);
    check("rst_busy", busy, 1);
    check("rst_status", in_game_status, NEXT_TURN);
    check("rst_turn", player_turn, 0);
    check("rst_invalid", invalid_column, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_clear();

    // Single drop: latency of write and check start.
    issue(3'd3, P1_TURN, 1'b0);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (board_we) begin
        k = i;
        break;
      end
    end
    check("write_latency", k, 2);
    check("first_cell", {board_row, board_col, board_piece}, {3'd0, 3'd3, 2'b01});
    @(negedge clk);
    check("chk_start_latency", chk_start, 1);
    wait_idle();
    check("after_first_turn", player_turn, 1);
    check("after_first_status", in_game_status, 2'b00);

    // Fill column 0, then overflow it.
    for (int i = 0; i < ROWS; i++) play(3'd0, 1'b0);
    play(3'd0, 1'b0);
    check("full_col_invalid", invalid_column, 1);
    check("full_col_turn", player_turn, 1);
    play(3'd1, 1'b0);
    check("valid_clears_invalid", invalid_column, 0);
    check("turn_after_col1", player_turn, 0);

    // Out-of-range column, wrong-player request, stray chk_done.
    play(3'd7, 1'b0);
    check("col7_invalid", invalid_column, 1);
    drop(3'd2, P2_TURN, 1'b0);
    check("wrong_player_busy", busy, 0);
    check("wrong_player_invalid_held", invalid_column, 1);
    @(posedge clk);
    #1 chk_done = 1'b1;
    chk_win = 1'b1;
    @(posedge clk);
    #1 chk_done = 1'b0;
    chk_win = 1'b0;
    @(negedge clk);
    check("stray_done_busy", busy, 0);
    check("stray_done_status", in_game_status, 2'b00);

    // Win by P2, then requests are ignored.
    play(3'd2, 1'b0);
    play(3'd2, 1'b1);
    check("p2_win_status", in_game_status, 2'b01);
    check("p2_win_turn", player_turn, 1);
    drop(3'd4, P2_TURN, 1'b0);
    drop(3'd4, P1_TURN, 1'b0);
    check("post_win_status", in_game_status, 2'b01);

    // Full board without a win ends in a tie.
    restart();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) play(3'(c), 1'b0);
    check("tie_status", in_game_status, 2'b10);
    check("tie_turn", player_turn, 1);

    // Win on the 42nd piece.
    restart();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) play(3'(c), (c == COLS - 1 && r == ROWS - 1));
    check("last_piece_win", in_game_status, 2'b01);
    check("last_piece_turn", player_turn, 1);

    // new_game during CHECK, then a late chk_done.
    restart();
    play(3'd5, 1'b0);
    auto_resp = 1'b0;
    issue(3'd5, P2_TURN, 1'b0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (chk_start) begin
        seen = 1;
        break;
      end
    end
    check("chk_start_seen", seen, 1);
    check("queue_empty_in_check", exp_q.size(), 0);
    @(posedge clk);
    #1 new_game = 1'b1;
    @(posedge clk);
    #1 new_game = 1'b0;
    chk_done = 1'b1;
    chk_win  = 1'b1;
    model_reset();
    fork
      begin
        @(posedge clk);
        #1 chk_done = 1'b0;
        chk_win = 1'b0;
      end
    join_none
    check_clear();
    auto_resp = 1'b1;
    check("ng_status", in_game_status, 2'b00);
    check("ng_turn", player_turn, 0);
    play(3'd5, 1'b0);
    check("ng_height_reset_turn", player_turn, 1);

    // Random games.
    for (int g = 0; g < 3; g++) begin
      restart();
      for (int d = 0; d < 60 && m_status == NEXT_TURN; d++) begin
        if ($urandom_range(0, 7) == 0) cs = 2'($urandom_range(0, 3));
        else                           cs = m_turn ? P2_TURN : P1_TURN;
        drop(3'($urandom_range(0, 7)), cs, ($urandom_range(0, 29) == 0));
      end
      drop(3'($urandom_range(0, 6)), P1_TURN, 1'b0);
      drop(3'($urandom_range(0, 6)), P2_TURN, 1'b0);
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
